// File: rtl/regfile_dual_write.sv
// 32 x 32 register file with two registered read ports and two write ports.
// Register 0 is hard-wired to zero; port 1 has priority when both ports write the same register.
module regfile_dual_write #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int RET_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] s_1,
  output logic [DATA_W-1:0] d_1,
  input  logic [ADDR_W-1:0] s_2,
  output logic [DATA_W-1:0] d_2,
  input  logic              we1,
  input  logic [ADDR_W-1:0] target_1,
  input  logic [DATA_W-1:0] write_data_1,
  input  logic              we2,
  input  logic [ADDR_W-1:0] target_2,
  input  logic [DATA_W-1:0] write_data_2,
  output logic [DATA_W-1:0] ret_val
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] RET_IDX = RET_REG[ADDR_W-1:0];

  logic [DATA_W-1:0] regs [DEPTH];
  logic              wr1_active;
  logic              wr2_active;
  logic [DATA_W-1:0] rd1_next;
  logic [DATA_W-1:0] rd2_next;

  assign wr1_active = we1 && (target_1 != '0);
  assign wr2_active = we2 && (target_2 != '0);

  // Read data reflects this edge's writes; port 1 is checked last so it wins.
  always_comb begin
    rd1_next = regs[s_1];
    if (wr2_active && (target_2 == s_1)) rd1_next = write_data_2;
    if (wr1_active && (target_1 == s_1)) rd1_next = write_data_1;
    if (s_1 == '0) rd1_next = '0;
  end

  always_comb begin
    rd2_next = regs[s_2];
    if (wr2_active && (target_2 == s_2)) rd2_next = write_data_2;
    if (wr1_active && (target_1 == s_2)) rd2_next = write_data_1;
    if (s_2 == '0) rd2_next = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      d_1 <= '0;
      d_2 <= '0;
    end else begin
      if (wr2_active) regs[target_2] <= write_data_2;
      if (wr1_active) regs[target_1] <= write_data_1;
      d_1 <= rd1_next;
      d_2 <= rd2_next;
    end
  end

  assign ret_val = regs[RET_IDX];

endmodule

// File: tb/tb_regfile_dual_write.sv
// Self-checking bench for regfile_dual_write: directed scenarios plus randomized
// traffic checked against an array-based reference model.
module tb_regfile_dual_write;

  logic        clk;
  logic        rst_n;
  logic [4:0]  s_1, s_2, target_1, target_2;
  logic [31:0] d_1, d_2, write_data_1, write_data_2, ret_val;
  logic        we1, we2;

  logic [31:0] model [32];
  logic [31:0] exp_d1, exp_d2;
  int          n_tests;
  int          n_fail;

  regfile_dual_write dut (
    .clk(clk), .rst_n(rst_n),
    .s_1(s_1), .d_1(d_1), .s_2(s_2), .d_2(d_2),
    .we1(we1), .target_1(target_1), .write_data_1(write_data_1),
    .we2(we2), .target_2(target_2), .write_data_2(write_data_2),
    .ret_val(ret_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and update the reference model from the inputs seen at that edge.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      exp_d1 = 32'h0;
      exp_d2 = 32'h0;
    end else begin
      if (we1 && target_1 != 5'd0) model[target_1] = write_data_1;
      if (we2 && target_2 != 5'd0 && !(we1 && target_1 == target_2)) model[target_2] = write_data_2;
      exp_d1 = (s_1 == 5'd0) ? 32'h0 : model[s_1];
      exp_d2 = (s_2 == 5'd0) ? 32'h0 : model[s_2];
    end
    #1;
  endtask

  task automatic idle_inputs();
    we1 = 1'b0; we2 = 1'b0;
    target_1 = 5'd0; target_2 = 5'd0;
    write_data_1 = 32'h0; write_data_2 = 32'h0;
    s_1 = 5'd0; s_2 = 5'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    we1 = 1'b1; target_1 = 5'd5; write_data_1 = 32'hDEAD;
    s_1 = 5'd5; s_2 = 5'd5;
    tick();
    tick();
    n_tests++;
    if (d_1 !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_d1 got %h want %h", d_1, 32'h0); end
    n_tests++;
    if (d_2 !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_d2 got %h want %h", d_2, 32'h0); end
    n_tests++;
    if (ret_val !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_ret got %h want %h", ret_val, 32'h0); end
    rst_n = 1'b1;
    idle_inputs();
    s_1 = 5'd5;
    tick();
    n_tests++;
    if (d_1 !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_write_ignored got %h want %h", d_1, 32'h0); end
  endtask

  task automatic test_basic();
    idle_inputs();
    we1 = 1'b1; target_1 = 5'd3; write_data_1 = 32'h12345678;
    we2 = 1'b1; target_2 = 5'd7; write_data_2 = 32'hCAFEF00D;
    tick();
    idle_inputs();
    s_1 = 5'd3; s_2 = 5'd7;
    tick();
    n_tests++;
    if (d_1 !== 32'h12345678) begin n_fail++; $display("[TB] FAIL basic_d1 got %h want %h", d_1, 32'h12345678); end
    n_tests++;
    if (d_2 !== 32'hCAFEF00D) begin n_fail++; $display("[TB] FAIL basic_d2 got %h want %h", d_2, 32'hCAFEF00D); end
  endtask

  task automatic test_zero();
    idle_inputs();
    we1 = 1'b1; target_1 = 5'd0; write_data_1 = 32'hFFFFFFFF;
    we2 = 1'b1; target_2 = 5'd0; write_data_2 = 32'h55555555;
    s_1 = 5'd0; s_2 = 5'd0;
    tick();
    n_tests++;
    if (d_1 !== 32'h0) begin n_fail++; $display("[TB] FAIL zero_same_edge got %h want %h", d_1, 32'h0); end
    we1 = 1'b0; we2 = 1'b0;
    tick();
    n_tests++;
    if (d_1 !== 32'h0 || d_2 !== 32'h0) begin
      n_fail++; $display("[TB] FAIL zero_later got %h/%h want 0/0", d_1, d_2);
    end
  endtask

  task automatic test_bypass();
    idle_inputs();
    we1 = 1'b1; target_1 = 5'd9; write_data_1 = 32'h00000001;
    tick();
    idle_inputs();
    s_1 = 5'd9;
    we2 = 1'b1; target_2 = 5'd9; write_data_2 = 32'hA5A5A5A5;
    tick();
    n_tests++;
    if (d_1 !== 32'hA5A5A5A5) begin n_fail++; $display("[TB] FAIL bypass_p2 got %h want %h", d_1, 32'hA5A5A5A5); end
    idle_inputs();
    s_2 = 5'd9;
    we1 = 1'b1; target_1 = 5'd9; write_data_1 = 32'h3C3C3C3C;
    tick();
    n_tests++;
    if (d_2 !== 32'h3C3C3C3C) begin n_fail++; $display("[TB] FAIL bypass_p1 got %h want %h", d_2, 32'h3C3C3C3C); end
  endtask

  task automatic test_conflict();
    idle_inputs();
    we1 = 1'b1; target_1 = 5'd4; write_data_1 = 32'h11;
    we2 = 1'b1; target_2 = 5'd4; write_data_2 = 32'h22;
    s_1 = 5'd4; s_2 = 5'd4;
    tick();
    n_tests++;
    if (d_1 !== 32'h11 || d_2 !== 32'h11) begin
      n_fail++; $display("[TB] FAIL conflict_bypass got %h/%h want 11/11", d_1, d_2);
    end
    we1 = 1'b0; we2 = 1'b0;
    tick();
    n_tests++;
    if (d_1 !== 32'h11 || d_2 !== 32'h11) begin
      n_fail++; $display("[TB] FAIL conflict_stored got %h/%h want 11/11", d_1, d_2);
    end
  endtask

  task automatic test_ret_val();
    idle_inputs();
    we1 = 1'b1; target_1 = 5'd1; write_data_1 = 32'h0000002A;
    #1;
    n_tests++;
    if (ret_val !== 32'h0) begin n_fail++; $display("[TB] FAIL ret_no_bypass got %h want %h", ret_val, 32'h0); end
    tick();
    n_tests++;
    if (ret_val !== 32'h2A) begin n_fail++; $display("[TB] FAIL ret_after_write got %h want %h", ret_val, 32'h2A); end
    idle_inputs();
    we1 = 1'b1; target_1 = 5'd2; write_data_1 = 32'h77777777;
    we2 = 1'b1; target_2 = 5'd6; write_data_2 = 32'h88888888;
    tick();
    n_tests++;
    if (ret_val !== 32'h2A) begin n_fail++; $display("[TB] FAIL ret_unchanged got %h want %h", ret_val, 32'h2A); end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      we1 = $urandom_range(0, 1);
      we2 = $urandom_range(0, 1);
      target_1 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      target_2 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      s_1 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      s_2 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      write_data_1 = $urandom;
      write_data_2 = $urandom;
      #1;
      n_tests++;
      if (ret_val !== model[1]) begin
        n_fail++; $display("[TB] FAIL rand_ret_pre cyc %0d got %h want %h", cyc, ret_val, model[1]);
      end
      tick();
      n_tests++;
      if (d_1 !== exp_d1 || d_2 !== exp_d2 || ret_val !== model[1]) begin
        n_fail++;
        $display("[TB] FAIL rand cyc %0d got d1=%h d2=%h ret=%h want d1=%h d2=%h ret=%h",
                 cyc, d_1, d_2, ret_val, exp_d1, exp_d2, model[1]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    we1 = 1'b1; target_1 = 5'd1; write_data_1 = 32'hBEEF0001;
    we2 = 1'b1; target_2 = 5'd12; write_data_2 = 32'hBEEF0002;
    tick();
    rst_n = 1'b0;
    write_data_1 = 32'hBAD00001; write_data_2 = 32'hBAD00002;
    s_1 = 5'd12; s_2 = 5'd1;
    tick();
    rst_n = 1'b1;
    n_tests++;
    if (d_1 !== 32'h0 || d_2 !== 32'h0 || ret_val !== 32'h0) begin
      n_fail++; $display("[TB] FAIL reset_mid got %h/%h/%h want 0/0/0", d_1, d_2, ret_val);
    end
    idle_inputs();
    for (int a = 0; a < 32; a += 2) begin
      s_1 = 5'(a); s_2 = 5'(a + 1);
      tick();
      n_tests++;
      if (d_1 !== 32'h0 || d_2 !== 32'h0) begin
        n_fail++; $display("[TB] FAIL reset_sweep addr %0d got %h/%h want 0/0", a, d_1, d_2);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    exp_d1 = 32'h0;
    exp_d2 = 32'h0;
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_basic();
    test_zero();
    test_bypass();
    test_conflict();
    test_ret_val();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_dual_write.md
Name: regfile_dual_write

Overview:
- 32-entry x 32-bit general-purpose register file for the Dioptase simple pipeline, instantiated inside the decode stage.
- Two synchronous read ports and two write ports. Write port 1 serves the primary destination; write port 2 serves the pre/post-increment base-register writeback.
- Register 0 is hard-wired to zero; target 0 means "no write".
- A combinational tap exposes the return-value register for the testbench and halt reporting.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width; depth is 2**ADDR_W = 32.
- RET_REG, 1, index of the register driven onto ret_val.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- s_1  input  5  read address, port 1.
- d_1  output  32  registered read data, port 1.
- s_2  input  5  read address, port 2.
- d_2  output  32  registered read data, port 2.
- we1  input  1  write enable, port 1.
- target_1  input  5  write address, port 1.
- write_data_1  input  32  write data, port 1.
- we2  input  1  write enable, port 2.
- target_2  input  5  write address, port 2.
- write_data_2  input  32  write data, port 2.
- ret_val  output  32  combinational current contents of register RET_REG.

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is synchronous and active-low.
- Reset: on a rising clk edge with rst_n=0:
  - all 32 registers clear to 0;
  - d_1 and d_2 clear to 0;
  - writes in that cycle are ignored.
- Write:
  - On a rising edge with rst_n=1, if weN=1 and target_N!=0, then reg[target_N] <= write_data_N.
  - A write to target 0 is discarded; reg[0] always reads 0.
- Simultaneous writes to the same nonzero target from both ports: port 1 wins. This is deterministic, not an X.
- Read:
  - d_N <= value of reg[s_N] after this edge's writes. The latency is one cycle, so the address presented in cycle t yields data in cycle t+1.
  - Read ports update every cycle. There is no enable and no stall input.
- Write-to-read bypass: if the same edge writes address A and s_N==A (A!=0), d_N takes the newly written data. When both ports write A, port 1's data is used, consistent with the write priority.
- s_N==0 always yields d_N=0, even if a write targets 0.
- ret_val is purely combinational from the register array. It reflects a write on the edge after which the write lands, with no bypass of the pending write.
- Both read ports may address the same register; both return the identical value.
- Reset asserted mid-operation takes precedence over any pending write or read in that cycle.
- No X propagation: all storage and outputs are initialised by reset.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with we1=1, target_1=5, write_data_1=0xDEAD -> d_1=d_2=0, ret_val=0; after release, s_1=5 reads 0.
- Basic write/read: write reg3=0x12345678 via port 1 and reg7=0xCAFEF00D via port 2 in the same cycle. Next cycle s_1=3, s_2=7 -> one cycle later d_1=0x12345678, d_2=0xCAFEF00D.
- Register zero: we1=1, target_1=0, write_data_1=0xFFFFFFFF with s_1=0 -> d_1=0 on that edge and all later edges.
- Bypass: s_1=9 while writing reg9=0xA5A5A5A5 on port 2 in the same cycle -> d_1=0xA5A5A5A5 after that edge, not the old value.
- Write conflict: we1=we2=1, target_1=target_2=4, data 0x11 and 0x22 -> reg4 reads 0x11.
- ret_val: write reg1=0x0000002A -> ret_val=0x2A immediately after the edge; writes to other registers leave ret_val unchanged.
